// File: rtl/fft_rad2_seq.sv
// In-place radix-2 DIT FFT address sequencer with write-back delay line.
// Optional per-stage cut table: define FFT_SEQ_CUT_TABLE_EN.
module fft_rad2_seq #(
    parameter int         LOG2N       = 10,
    parameter int         MEM_LAT     = 1,
    parameter int         BF_LAT      = 2,
    parameter logic [3:0] CUT_DEFAULT = 4'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
`ifdef FFT_SEQ_CUT_TABLE_EN
    input  logic [4*LOG2N-1:0] cut_table,
`endif
    output logic               busy,
    output logic               done,
    output logic               rd_en,
    output logic [LOG2N-1:0]   rd_addr_a,
    output logic [LOG2N-1:0]   rd_addr_b,
    output logic [LOG2N-2:0]   tw_addr,
    output logic               wr_en,
    output logic [LOG2N-1:0]   wr_addr_a,
    output logic [LOG2N-1:0]   wr_addr_b,
    output logic [3:0]         stage,
    output logic [3:0]         cut
);

    localparam int W = LOG2N;
    localparam int D = MEM_LAT + BF_LAT;

    localparam logic [W-2:0] K_LAST = '1;
    localparam logic [W-2:0] K_ONE  = (W-1)'(1);
    localparam logic [3:0]   S_LAST = 4'(LOG2N - 1);
    localparam logic [7:0]   D_LAST = 8'(D - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t       state_q, state_d;
    logic [W-2:0] k_q, k_d;
    logic [3:0]   s_q, s_d;
    logic [7:0]   dc_q, dc_d;
    logic         flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            s_q     <= '0;
            dc_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            dc_q    <= dc_d;
        end
    end

    assign flush = abort && (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        dc_d    = dc_q;
        if (flush) begin
            state_d = IDLE;
            k_d     = '0;
            s_d     = '0;
            dc_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    k_d = k_q + K_ONE;
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        dc_d    = '0;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    dc_d = dc_q + 8'd1;
                    if (dc_q == D_LAST) begin
                        dc_d = '0;
                        if (s_q == S_LAST) begin
                            state_d = FIN;
                        end else begin
                            s_d     = s_q + 4'd1;
                            state_d = RUN;
                        end
                    end
                end
                FIN: begin
                    s_d     = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Butterfly pair and twiddle index from (stage, k)
    logic [W-1:0] span, grp, addr_a, addr_b;
    logic [W-2:0] mask, pos, tw;
    logic [3:0]   tsh;

    always_comb begin
        span   = W'(1) << s_q;
        mask   = (W-1)'(span - W'(1));
        pos    = k_q & mask;
        grp    = W'(k_q) >> s_q;
        addr_a = (grp << (s_q + 4'd1)) | W'(pos);
        addr_b = addr_a + span;
        tsh    = S_LAST - s_q;
        tw     = pos << tsh;
    end

    assign rd_en     = (state_q == RUN);
    assign rd_addr_a = rd_en ? addr_a : '0;
    assign rd_addr_b = rd_en ? addr_b : '0;
    assign tw_addr   = rd_en ? tw : '0;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == FIN);

    logic [D-1:0] wen_q;
    logic [W-1:0] wa_q [D];
    logic [W-1:0] wb_q [D];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q <= '0;
            for (int i = 0; i < D; i++) begin
                wa_q[i] <= '0;
                wb_q[i] <= '0;
            end
        end else if (flush) begin
            wen_q <= '0;
            for (int i = 0; i < D; i++) begin
                wa_q[i] <= '0;
                wb_q[i] <= '0;
            end
        end else begin
            wen_q[0] <= rd_en;
            wa_q[0]  <= rd_addr_a;
            wb_q[0]  <= rd_addr_b;
            for (int i = 1; i < D; i++) begin
                wen_q[i] <= wen_q[i-1];
                wa_q[i]  <= wa_q[i-1];
                wb_q[i]  <= wb_q[i-1];
            end
        end
    end

    assign wr_en     = wen_q[D-1];
    assign wr_addr_a = wa_q[D-1];
    assign wr_addr_b = wb_q[D-1];

    logic [3:0] cut_src;
`ifdef FFT_SEQ_CUT_TABLE_EN
    assign cut_src = cut_table[4*s_q +: 4];
`else
    assign cut_src = CUT_DEFAULT;
`endif

    // Stage/cut travel with the RAM/ROM read latency
    logic [3:0] st_q [MEM_LAT];
    logic [3:0] ct_q [MEM_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                st_q[i] <= '0;
                ct_q[i] <= '0;
            end
        end else begin
            st_q[0] <= s_q;
            ct_q[0] <= cut_src;
            for (int i = 1; i < MEM_LAT; i++) begin
                st_q[i] <= st_q[i-1];
                ct_q[i] <= ct_q[i-1];
            end
        end
    end

    assign stage = st_q[MEM_LAT-1];
    assign cut   = ct_q[MEM_LAT-1];

endmodule

// File: doc/fft_rad2_seq.md
Name: fft_rad2_seq

Overview:
- In-place radix-2 DIT FFT sequencer. It drives the data RAM read/write ports and the twiddle ROM address, and sits directly upstream of butterfly_Rad2 in the acquisition FFT path.
- It walks LOG2N stages of N/2 butterflies, issuing A/B read addresses and a twiddle index each cycle.
- It delays those addresses to produce write-back addresses aligned with butterfly output, and drains the pipeline between stages.
- The upstream loader writes the data RAM in bit-reversed order before start.

Parameters:
- LOG2N, 10, log2 of FFT length N (valid 2..12)
- MEM_LAT, 1, data RAM and twiddle ROM read latency in cycles (both equal)
- BF_LAT, 2, butterfly_Rad2 input-to-output latency in cycles
- CUT_DEFAULT, 4'd1, cut value used when FFT_SEQ_CUT_TABLE_EN is not defined

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle request to begin a transform; ignored while busy
- abort  in  1  synchronous abort
- busy  out  1  high from first read until last write
- done  out  1  one-cycle pulse after last write
- rd_en  out  1  data RAM read strobe
- rd_addr_a  out  LOG2N  butterfly A read address
- rd_addr_b  out  LOG2N  butterfly B read address
- tw_addr  out  LOG2N-1  twiddle ROM index, issued with rd_en
- wr_en  out  1  data RAM write strobe for C/D results
- wr_addr_a  out  LOG2N  C write address
- wr_addr_b  out  LOG2N  D write address
- stage  out  4  current stage, aligned with butterfly inputs
- cut  out  4  butterfly cut value, aligned with butterfly inputs

Behaviour:
- Reset (async, rst=1): state=IDLE, all outputs 0, counters 0.
- States:
  - IDLE: wait for start.
  - RUN: one butterfly per cycle.
  - DRAIN: wait D = MEM_LAT+BF_LAT cycles.
  - FIN: one cycle.
- IDLE -> RUN on start=1. First rd_en occurs the cycle after start is sampled.
- RUN: stage s, butterfly index k = 0..N/2-1.
  - span = 1<<s
  - pos = k & (span-1)
  - grp = k >> s
  - rd_addr_a = (grp<<(s+1)) | pos
  - rd_addr_b = rd_addr_a + span
  - tw_addr = pos << (LOG2N-1-s)
  - rd_en = 1
- At k = N/2-1: RUN -> DRAIN and k resets to 0.
- DRAIN holds rd_en = 0 for exactly D cycles. This prevents the read-after-write hazard on in-place data.
- After DRAIN:
  - If s < LOG2N-1: s increments, go to RUN.
  - Else: go to FIN.
- FIN: done = 1 for one cycle, busy = 0, then IDLE.
- Write path: wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed by exactly D cycles (shift register, reset to 0).
- stage and cut are delayed by MEM_LAT, so they align with RAM/ROM data at the butterfly inputs.
- busy = 1 from the first rd_en cycle through the last wr_en cycle inclusive.
- start while busy, or during FIN: ignored, no restart.
- abort=1, any state except IDLE:
  - Next cycle: state=IDLE, rd_en=0, wr_en=0 and delay line flushed.
  - done is not pulsed and busy drops.
- abort and start in the same cycle in IDLE: abort wins, stay IDLE.
- Counters never wrap mid-stage. k wraps only at stage end; s never exceeds LOG2N-1.

Optional Feature:
- Macro FFT_SEQ_CUT_TABLE_EN.
- Defined:
  - Adds input cut_table [4*LOG2N-1:0].
  - cut = cut_table[4*stage +: 4], sampled per stage and aligned as above.
- Undefined: no cut_table port; cut = CUT_DEFAULT constantly (0 during reset).

Test Plan:
- LOG2N=3, MEM_LAT=1, BF_LAT=2, start at cycle 0:
  - Reads at cycles 1-4: pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0.
  - Reads at cycles 8-11: pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
  - Reads at cycles 15-18: pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
- Same run, write path:
  - wr_en in cycles 4-7, 11-14 and 18-21, with addresses equal to the reads 3 cycles earlier.
  - No cycle where rd_en overlaps a pending write of the same stage.
  - done pulse at cycle 22; busy high on cycles 1-21.
- Start pulsed again at cycle 9 during the run -> ignored; the sequence and done timing are unchanged.
- abort at cycle 10 -> rd_en=0 and wr_en=0 from cycle 11, busy=0, no done. A fresh start then reproduces the first scenario exactly.
- rst asserted at cycle 6 (asynchronous, mid-edge) -> all outputs 0 immediately. After release, the FSM is in IDLE with no spurious writes.
- FFT_SEQ_CUT_TABLE_EN defined, cut_table={4'd3,4'd2,4'd1} -> cut = 1, 2, 3 during stages 0, 1, 2, each aligned one cycle after the corresponding reads. Undefined, CUT_DEFAULT=1 -> cut = 1 throughout.
